hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller that sits beside the decode stage and sequences the IF/ID and ID/EX boundaries. It keeps a scoreboard of in-flight multiplies and detects load-use RAW hazards and writeback-port conflicts. On a hazard it freezes fetch and inserts a bubble into ID/EX. On a memory stall it freezes the whole front end. It also keeps stall statistics.

Parameters:
MUL_STAGES, 5, depth of the multiply pipeline (M1..Mn) before WB; legal range 3..8.
ALU_WB_LAT, 3, cycles from ID/EX issue to WB for non-mult instructions (EX, MEM, WB).
REG_ADDR, 5, register address width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
dec_valid  in  1  IF/ID holds a real instruction.
dec_src1  in  REG_ADDR  decode source register 1 (instr[25:21]).
dec_src2  in  REG_ADDR  decode source register 2 (instr[20:16]).
dec_use1  in  1  instruction reads src1.
dec_use2  in  1  instruction reads src2.
dec_dest  in  REG_ADDR  decode destination register.
dec_regwrite  in  1  decoded instruction writes the register file.
dec_is_mult  in  1  decoded instruction is OP_RTYPE/FN_MUL.
ex_memread  in  1  instruction now in ID/EX is a load.
ex_dest  in  REG_ADDR  destination register of ID/EX.
mem_stall  in  1  memory stage busy; global freeze.
fetch_we  out  1  PC and IF/ID write enable.
decode_we  out  1  ID/EX write enable (decode stage `we`).
bubble  out  1  zero control signals into ID/EX (decode stage `stall`).
stall_cause  out  2  0 none, 1 mem, 2 RAW, 3 WB-port conflict.
stall_count  out  32  total cycles with stall_cause != 0.
raw_count  out  32  cycles with stall_cause == 2.

Behaviour:
- Scoreboard: slots 1..MUL_STAGES, each holding {valid, dest}. Slot 1 is the multiply issued in the previous cycle.
- Every cycle with mem_stall=0, all slots shift: slot k goes to k+1, and slot MUL_STAGES retires.
  - Slot 1 is loaded with {issue_mul, dec_dest}.
  - issue_mul = issue & dec_is_mult & dec_regwrite & (dec_dest != 0).
- When mem_stall=1, the scoreboard and counters-by-cause hold; only stall_count and the mem-cause increment apply.
- issue = dec_valid & ~mem_stall & ~raw & ~wbc.
- raw (register 0 never matches) is set when either:
  - mul RAW: any valid slot with dest == dec_src1 & dec_use1, or dest == dec_src2 & dec_use2; or
  - load-use: ex_memread & ex_dest != 0 & ex_dest matches a used source.
- wbc = dec_valid & dec_regwrite & ~dec_is_mult & slot[MUL_STAGES-ALU_WB_LAT+1].valid. This is the mul that would reach WB in the same cycle as this ALU op.
- Priority is mem_stall > raw > wbc. Outputs are combinational from current state and inputs, with zero latency.
- Output modes:
  - mem: fetch_we=0, decode_we=0, bubble=0.
  - raw/wbc: fetch_we=0, decode_we=1, bubble=1.
  - none: fetch_we=1, decode_we=1, bubble=0.
- dec_valid=0 is never a stall: fetch_we=1, decode_we=1, bubble=0.
- Reset (while high, and for the cycle it applies): all slots invalid, both counters 0, fetch_we=0, decode_we=0, bubble=1, stall_cause=0.
- Reset mid-operation discards all in-flight scoreboard entries. No retirement side effects occur.
- Counters wrap modulo 2^32 without saturation.
- Simultaneous mul retiring from the last slot and a dependent decode: the retiring slot still matches this cycle. The register file is write-first, so the instruction issues next cycle.
- Back-to-back multiplies to the same dest are legal: both slots are tracked and a dependent waits for the younger one.

Decomposition:
- Add STALL_NONE/STALL_MEM/STALL_RAW/STALL_WBC encodings to define.v next to the OP_/FN_ constants.
- One sub-module, mul_scoreboard: a shift register of {valid, dest} with an advance enable and per-slot compare outputs for src1/src2.
- hazard_ctrl holds the priority logic, output modes and counters.

Test Plan:
1. `mul r3,r1,r2` issues, then `add r4,r3,r5` is decoded → raw=1 for MUL_STAGES cycles (5), bubble=1, fetch_we=0, stall_cause=2 each cycle; issue on the 6th; raw_count=5.
2. ID/EX `lw r7` with ex_memread=1, decode `add r8,r7,r7` → one stall cycle with stall_cause=2; next cycle ex_memread=0 → issue. Same sequence with ex_dest=0 → no stall.
3. Mul issued at t, non-mul regwrite decoded at t+3 (slot 3 valid, MUL_STAGES=5) → stall_cause=3 for one cycle, then issue. Same case with dec_regwrite=0 (store) → no stall.
4. mem_stall=1 for 4 cycles with a mul in slot 2 → fetch_we=0, decode_we=0, bubble=0; slot stays at 2; stall_count +4; raw_count unchanged.
5. Reset asserted while 3 slots are valid → next cycle all slots invalid; a dependent instruction of the killed mul issues immediately; both counters read 0.
6. Mul to r0 followed by a reader of r0 → no scoreboard entry, no stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: stall causes and the
// per-cause control mode driven onto the IF/ID and ID/EX boundaries.
package hazard_ctrl_pkg;

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_MEM  = 2'd1;
  localparam logic [1:0] STALL_RAW  = 2'd2;
  localparam logic [1:0] STALL_WBC  = 2'd3;

  typedef struct packed {
    logic fetch_we;
    logic decode_we;
    logic bubble;
  } ctrl_mode_t;

  localparam ctrl_mode_t MODE_RUN    = '{fetch_we: 1'b1, decode_we: 1'b1, bubble: 1'b0};
  localparam ctrl_mode_t MODE_FREEZE = '{fetch_we: 1'b0, decode_we: 1'b0, bubble: 1'b0};
  localparam ctrl_mode_t MODE_BUBBLE = '{fetch_we: 1'b0, decode_we: 1'b1, bubble: 1'b1};
  localparam ctrl_mode_t MODE_RESET  = '{fetch_we: 1'b0, decode_we: 1'b0, bubble: 1'b1};

  // Map a stall cause onto the boundary control mode.
  function automatic ctrl_mode_t mode_for(input logic [1:0] cause);
    ctrl_mode_t m;
    unique case (cause)
      STALL_MEM:             m = MODE_FREEZE;
      STALL_RAW, STALL_WBC:  m = MODE_BUBBLE;
      default:               m = MODE_RUN;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mul_scoreboard.sv
// Scoreboard of in-flight multiplies: a shift register of {valid, dest}
// (index 0 = slot 1, the multiply issued last cycle) with per-slot
// source-match outputs and the valid bit of the slot that collides with
// an ALU writeback.
module mul_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 5,
  parameter int unsigned AW     = 5,
  parameter int unsigned WB_IDX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              load_valid,
  input  logic [AW-1:0]     load_dest,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  output logic [STAGES-1:0] hit1,
  output logic [STAGES-1:0] hit2,
  output logic              wb_valid
);

  logic [STAGES-1:0]         valid_q, valid_d;
  logic [STAGES-1:0][AW-1:0] dest_q,  dest_d;

  // Shift every slot one stage older when advancing; hold otherwise.
  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    if (advance) begin
      valid_d[0] = load_valid;
      dest_d[0]  = load_dest;
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
    end
  end

  // Slot storage; reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
    end
  end

  // Per-slot source compares; register 0 never matches.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      hit1[k] = valid_q[k] && (dest_q[k] == src1) && (src1 != '0);
      hit2[k] = valid_q[k] && (dest_q[k] == src2) && (src2 != '0);
    end
  end

  assign wb_valid = valid_q[WB_IDX];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside decode: mul RAW / load-use / WB-port conflict
// detection, boundary control for IF/ID and ID/EX, and stall statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_STAGES = 5,
  parameter int unsigned ALU_WB_LAT = 3,
  parameter int unsigned REG_ADDR   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [REG_ADDR-1:0] dec_src1,
  input  logic [REG_ADDR-1:0] dec_src2,
  input  logic                dec_use1,
  input  logic                dec_use2,
  input  logic [REG_ADDR-1:0] dec_dest,
  input  logic                dec_regwrite,
  input  logic                dec_is_mult,
  input  logic                ex_memread,
  input  logic [REG_ADDR-1:0] ex_dest,
  input  logic                mem_stall,
  output logic                fetch_we,
  output logic                decode_we,
  output logic                bubble,
  output logic [1:0]          stall_cause,
  output logic [31:0]         stall_count,
  output logic [31:0]         raw_count
);

  // Slot MUL_STAGES-ALU_WB_LAT+1 (1-based) reaches WB together with an ALU op issued now.
  localparam int unsigned WB_IDX = MUL_STAGES - ALU_WB_LAT;

  logic [MUL_STAGES-1:0] hit1, hit2;
  logic                  wb_valid;
  logic                  raw, wbc, issue, issue_mul;
  logic [1:0]            cause;
  ctrl_mode_t            mode;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [31:0]           raw_cnt_q,   raw_cnt_d;

  mul_scoreboard #(
    .STAGES (MUL_STAGES),
    .AW     (REG_ADDR),
    .WB_IDX (WB_IDX)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .advance    (~mem_stall),
    .load_valid (issue_mul),
    .load_dest  (dec_dest),
    .src1       (dec_src1),
    .src2       (dec_src2),
    .hit1       (hit1),
    .hit2       (hit2),
    .wb_valid   (wb_valid)
  );

  // Hazard detection and cause priority: mem > raw > wbc.
  always_comb begin
    raw = dec_valid && (
            (dec_use1 && (|hit1)) || (dec_use2 && (|hit2)) ||
            (ex_memread && (ex_dest != '0) &&
             ((dec_use1 && (ex_dest == dec_src1)) || (dec_use2 && (ex_dest == dec_src2)))));
    wbc = dec_valid && dec_regwrite && !dec_is_mult && wb_valid;
    issue     = dec_valid && !mem_stall && !raw && !wbc;
    issue_mul = issue && dec_is_mult && dec_regwrite && (dec_dest != '0);
    if (mem_stall)  cause = STALL_MEM;
    else if (raw)   cause = STALL_RAW;
    else if (wbc)   cause = STALL_WBC;
    else            cause = STALL_NONE;
    mode = mode_for(cause);
  end

  // Statistics counters, wrapping modulo 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, (cause != STALL_NONE)};
    raw_cnt_d   = raw_cnt_q   + {31'd0, (cause == STALL_RAW)};
  end

  // Counter storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      raw_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      raw_cnt_q   <= raw_cnt_d;
    end
  end

  // Reset overrides the outputs combinationally so they are defined during the reset cycle itself.
  always_comb begin
    if (reset) begin
      {fetch_we, decode_we, bubble} = MODE_RESET;
      stall_cause = STALL_NONE;
      stall_count = '0;
      raw_count   = '0;
    end else begin
      {fetch_we, decode_we, bubble} = mode;
      stall_cause = cause;
      stall_count = stall_cnt_q;
      raw_count   = raw_cnt_q;
    end
  end

endmodule
